i2s_codec_master: RTL and testbench

- Codec-side end of the team's I2S audio link: generates BCLK and LRCK from the system clock.
- Serialises stereo ADC sample pairs onto ADCDAT for the recorder, and deserialises DACDAT driven by the player into stereo sample pairs.
- Used as the clock master in place of the external codec for loopback and simulation, and as the master when the codec runs in slave mode.
- Standard I2S framing: left slot when LRCK=0, MSB one BCLK after each LRCK transition.

---
 rtl/i2s_codec_master.sv | 192 +++++++++++++++++++
 tb/tb_i2s_codec_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_codec_master.sv
// I2S clock master for the codec side of the audio link.
// Generates BCLK/LRCK from i_clk, serialises ADC sample pairs onto o_adcdat
// and deserialises i_dacdat into DAC sample pairs. Standard I2S framing:
// left slot while LRCK=0, MSB one BCLK after each LRCK transition.
// Ports:
//   i_clk, i_rst_n        system clock, async active-low reset
//   i_en                  run request (a stop completes the current frame)
//   i_adc_l/r, o_adc_req  ADC pair, latched at frame start (req pulses then)
//   o_bclk, o_lrck        bit clock, channel select (0 = left)
//   o_adcdat              serial ADC data
//   i_dacdat              serial DAC data
//   o_dac_l/r, o_dac_valid  received DAC pair, valid pulses on update
module i2s_codec_master #(
    parameter int unsigned BCLK_DIV  = 2,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned WORD_BITS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [WORD_BITS-1:0] i_adc_l,
    input  logic [WORD_BITS-1:0] i_adc_r,
    output logic                 o_adc_req,
    output logic                 o_bclk,
    output logic                 o_lrck,
    output logic                 o_adcdat,
    input  logic                 i_dacdat,
    output logic [WORD_BITS-1:0] o_dac_l,
    output logic [WORD_BITS-1:0] o_dac_r,
    output logic                 o_dac_valid
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned K_W   = $clog2(SLOT_BITS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_W-1:0]      r_div;
    logic                  r_bclk;
    logic                  r_slot;
    logic [K_W-1:0]        r_k;
    logic [WORD_BITS-1:0]  r_tx_l;
    logic [WORD_BITS-1:0]  r_tx_r;
    logic [WORD_BITS-1:0]  r_rx_l;
    logic [WORD_BITS-1:0]  r_rx_r;

    logic                  w_wrap;
    logic                  w_fall;
    logic                  w_rise;
    logic [K_W-1:0]        w_k_nxt;
    logic                  w_slot_nxt;
    logic                  w_to_idle;
    logic                  w_frame_start;
    logic                  w_tx_bit;
    logic                  w_rx_bit;

    assign o_bclk = r_bclk;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bit-clock event decode
    always_comb begin
        w_state_nxt = r_state;
        w_fall      = 1'b0;
        w_rise      = 1'b0;
        w_k_nxt     = r_k;
        w_slot_nxt  = r_slot;
        w_to_idle   = 1'b0;
        w_wrap      = (r_div == DIV_W'(BCLK_DIV - 1));

        if (r_state == S_IDLE) begin
            // Leaving idle is itself the first falling event, at k=0 left.
            if (i_en) begin
                w_fall      = 1'b1;
                w_k_nxt     = '0;
                w_slot_nxt  = 1'b0;
                w_state_nxt = S_RUN;
            end
        end else begin
            w_fall = w_wrap && r_bclk;
            w_rise = w_wrap && !r_bclk;
            if (w_fall) begin
                if (r_k == K_W'(SLOT_BITS - 1)) begin
                    w_k_nxt    = '0;
                    w_slot_nxt = ~r_slot;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            if (r_state == S_RUN) begin
                if (!i_en) begin
                    w_state_nxt = S_STOP;
                end
            end else if (i_en) begin
                w_state_nxt = S_RUN;
            end else if (w_fall && (w_k_nxt == '0) && !w_slot_nxt) begin
                // Stop lands exactly where the next frame would have begun.
                w_state_nxt = S_IDLE;
                w_to_idle   = 1'b1;
            end
        end

        w_frame_start = w_fall && (w_k_nxt == '0) && !w_slot_nxt && !w_to_idle;
        w_tx_bit      = (w_k_nxt != '0) && (w_k_nxt <= K_W'(WORD_BITS));
        w_rx_bit      = (r_k != '0) && (r_k <= K_W'(WORD_BITS));
    end

    // Divider, framing, serialiser and deserialiser
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div       <= '0;
            r_bclk      <= 1'b0;
            r_slot      <= 1'b0;
            r_k         <= '0;
            r_tx_l      <= '0;
            r_tx_r      <= '0;
            r_rx_l      <= '0;
            r_rx_r      <= '0;
            o_lrck      <= 1'b0;
            o_adcdat    <= 1'b0;
            o_adc_req   <= 1'b0;
            o_dac_l     <= '0;
            o_dac_r     <= '0;
            o_dac_valid <= 1'b0;
        end else begin
            o_adc_req   <= 1'b0;
            o_dac_valid <= 1'b0;
            if (((r_state == S_IDLE) && !i_en) || w_to_idle) begin
                r_div    <= '0;
                r_bclk   <= 1'b0;
                r_slot   <= 1'b0;
                r_k      <= '0;
                o_lrck   <= 1'b0;
                o_adcdat <= 1'b0;
            end else begin
                if ((r_state == S_IDLE) || w_wrap) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end

                if (w_fall) begin
                    r_bclk <= 1'b0;
                    r_k    <= w_k_nxt;
                    r_slot <= w_slot_nxt;
                    o_lrck <= w_slot_nxt;
                    if (w_frame_start) begin
                        r_tx_l    <= i_adc_l;
                        r_tx_r    <= i_adc_r;
                        o_adc_req <= 1'b1;
                        o_adcdat  <= 1'b0;
                    end else if (w_tx_bit) begin
                        if (w_slot_nxt) begin
                            {o_adcdat, r_tx_r} <= {r_tx_r, 1'b0};
                        end else begin
                            {o_adcdat, r_tx_l} <= {r_tx_l, 1'b0};
                        end
                    end else begin
                        o_adcdat <= 1'b0;
                    end
                end

                if (w_rise) begin
                    r_bclk <= 1'b1;
                    if (w_rx_bit) begin
                        if (r_slot) begin
                            r_rx_r <= {r_rx_r[WORD_BITS-2:0], i_dacdat};
                        end else begin
                            r_rx_l <= {r_rx_l[WORD_BITS-2:0], i_dacdat};
                        end
                        // Last data bit of the right slot completes the pair.
                        if (r_slot && (r_k == K_W'(WORD_BITS))) begin
                            o_dac_l     <= r_rx_l;
                            o_dac_r     <= {r_rx_r[WORD_BITS-2:0], i_dacdat};
                            o_dac_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_master.sv
// Directed bench for i2s_codec_master at default parameters.
module tb_i2s_codec_master;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] adc_l;
    logic [15:0] adc_r;
    logic        adc_req;
    logic        bclk;
    logic        lrck;
    logic        adcdat;
    logic        dacdat;
    logic [15:0] dac_l;
    logic [15:0] dac_r;
    logic        dac_valid;

    logic        loop_en;
    logic        dacdat_drv;

    assign dacdat = loop_en ? adcdat : dacdat_drv;

    i2s_codec_master #(.BCLK_DIV(2), .SLOT_BITS(32), .WORD_BITS(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_adc_l     (adc_l),
        .i_adc_r     (adc_r),
        .o_adc_req   (adc_req),
        .o_bclk      (bclk),
        .o_lrck      (lrck),
        .o_adcdat    (adcdat),
        .i_dacdat    (dacdat),
        .o_dac_l     (dac_l),
        .o_dac_r     (dac_r),
        .o_dac_valid (dac_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: tracks bit index from BCLK/LRCK, captures ADC bits,
    // drives DAC bits, measures periods.
    int          mk = 0;
    int          mslot = 0;
    logic [15:0] cap_l = '0;
    logic [15:0] cap_r = '0;
    int          pad_err = 0;
    logic [15:0] drv_l = '0;
    logic [15:0] drv_r = '0;
    logic [15:0] next_drv_l = '0;
    logic [15:0] next_drv_r = '0;
    int          req_cnt = 0;
    int          valid_cnt = 0;
    int          last_req = 0, req_period = 0;
    int          last_rise = 0, rise_period = 0;
    int          last_lr = 0, lr_period = 0;
    logic        prev_bclk = 1'b0;
    logic        prev_lrck = 1'b0;

    initial dacdat_drv = 1'b1;

    always @(negedge clk) begin
        if (adc_req) begin
            mk      = 0;
            mslot   = 0;
            cap_l   = '0;
            cap_r   = '0;
            pad_err = (adcdat !== 1'b0) ? 1 : 0;
            drv_l   = next_drv_l;
            drv_r   = next_drv_r;
            req_cnt++;
            req_period = cyc - last_req;
            last_req   = cyc;
            dacdat_drv = 1'b1;
        end else if (prev_bclk && !bclk) begin
            if (lrck != prev_lrck) mk = 0;
            else mk++;
            mslot = lrck ? 1 : 0;
            if (mk >= 1 && mk <= 16) begin
                if (mslot == 1) begin
                    cap_r      = {cap_r[14:0], adcdat};
                    dacdat_drv = drv_r[4'(16 - mk)];
                end else begin
                    cap_l      = {cap_l[14:0], adcdat};
                    dacdat_drv = drv_l[4'(16 - mk)];
                end
            end else begin
                if (adcdat !== 1'b0) pad_err++;
                dacdat_drv = 1'b1;   // padding garbage must be ignored
            end
        end
        if (!prev_bclk && bclk) begin
            rise_period = cyc - last_rise;
            last_rise   = cyc;
        end
        if (!prev_lrck && lrck) begin
            lr_period = cyc - last_lr;
            last_lr   = cyc;
        end
        if (dac_valid) valid_cnt++;
        prev_bclk = bclk;
        prev_lrck = lrck;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // which: 0 = o_adc_req, 1 = o_dac_valid
    task automatic wait_pulse(input int which, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if ((which == 0 && adc_req) || (which == 1 && dac_valid)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL timeout waiting for %s", (which == 0) ? "adc_req" : "dac_valid");
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] adc_l;
        logic [15:0] adc_r;
        logic [15:0] dac_l;     // word the bench drives on i_dacdat
        logic [15:0] dac_r;
        logic [15:0] exp_ser_l; // expected o_adcdat bits k=1..16, MSB first
        logic [15:0] exp_ser_r;
        logic [15:0] exp_dac_l;
        logic [15:0] exp_dac_r;
    } vec_t;

    vec_t vt[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int snap;
        int hi_cnt;

        vt[0] = '{"spec",    16'hA5C3, 16'h0F81, 16'h1234, 16'hFEDC,
                  16'b1010010111000011, 16'b0000111110000001, 16'h1234, 16'hFEDC};
        vt[1] = '{"extreme", 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF,
                  16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        vt[2] = '{"edges",   16'h8001, 16'h7FFE, 16'h8000, 16'h0001,
                  16'h8001, 16'h7FFE, 16'h8000, 16'h0001};
        vt[3] = '{"alt",     16'h5555, 16'hAAAA, 16'h6DB6, 16'h9249,
                  16'h5555, 16'hAAAA, 16'h6DB6, 16'h9249};

        rst_n   = 1'b0;
        en      = 1'b0;
        loop_en = 1'b0;
        adc_l   = '0;
        adc_r   = '0;
        repeat (3) @(negedge clk);

        chk("reset bclk", 32'(bclk), 32'd0);
        chk("reset lrck", 32'(lrck), 32'd0);
        chk("reset adcdat", 32'(adcdat), 32'd0);
        chk("reset adc_req", 32'(adc_req), 32'd0);
        chk("reset dac_l", 32'(dac_l), 32'd0);
        chk("reset dac_r", 32'(dac_r), 32'd0);
        chk("reset dac_valid", 32'(dac_valid), 32'd0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle clocks held", 32'({bclk, lrck, adcdat, adc_req}), 32'd0);

        // Request pulses one cycle after i_en is sampled.
        en = 1'b1;
        @(negedge clk);
        chk("first adc_req latency", 32'(adc_req), 32'd1);

        for (int v = 0; v < 4; v++) begin
            adc_l      = vt[v].adc_l;
            adc_r      = vt[v].adc_r;
            next_drv_l = vt[v].dac_l;
            next_drv_r = vt[v].dac_r;
            wait_pulse(0, 400, ok);
            wait_pulse(1, 400, ok);
            if (ok) begin
                chk({vt[v].name, " dac_l"}, 32'(dac_l), 32'(vt[v].exp_dac_l));
                chk({vt[v].name, " dac_r"}, 32'(dac_r), 32'(vt[v].exp_dac_r));
                chk({vt[v].name, " adcdat left"}, 32'(cap_l), 32'(vt[v].exp_ser_l));
                chk({vt[v].name, " adcdat right"}, 32'(cap_r), 32'(vt[v].exp_ser_r));
                chk({vt[v].name, " adcdat padding"}, 32'(pad_err), 32'd0);
                @(negedge clk);
                chk({vt[v].name, " valid one cycle"}, 32'(dac_valid), 32'd0);
            end
        end

        chk("bclk period", 32'(rise_period), 32'd4);
        chk("lrck period", 32'(lr_period), 32'd256);
        chk("adc_req period", 32'(req_period), 32'd256);

        snap = valid_cnt;
        repeat (100) @(negedge clk);
        chk("dac_l held", 32'(dac_l), 32'h9249_0000 >> 16 == 0 ? 32'h0 : 32'(vt[3].exp_dac_l));
        chk("no extra valid", 32'(valid_cnt - snap), 32'd0);

        // Loopback: serial output fed straight back as DAC input.
        loop_en = 1'b1;
        adc_l   = 16'h8001;
        adc_r   = 16'h7FFE;
        wait_pulse(0, 400, ok);
        for (int f = 0; f < 2; f++) begin
            wait_pulse(1, 400, ok);
            if (ok) begin
                chk("loopback dac_l", 32'(dac_l), 32'h8001);
                chk("loopback dac_r", 32'(dac_r), 32'h7FFE);
            end
        end
        loop_en = 1'b0;

        // Drop i_en mid-left-slot: frame completes, then clocks stop.
        adc_l      = 16'hA5C3;
        adc_r      = 16'h0F81;
        next_drv_l = 16'hCAFE;
        next_drv_r = 16'hBEEF;
        wait_pulse(0, 400, ok);
        repeat (20) @(negedge clk);
        en   = 1'b0;
        snap = req_cnt;
        wait_pulse(1, 400, ok);
        if (ok) begin
            chk("stop dac_l", 32'(dac_l), 32'hCAFE);
            chk("stop dac_r", 32'(dac_r), 32'hBEEF);
        end
        repeat (100) @(negedge clk);
        hi_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bclk || lrck || adcdat) hi_cnt++;
        end
        chk("stopped clocks idle", 32'(hi_cnt), 32'd0);
        chk("stopped no adc_req", 32'(req_cnt - snap), 32'd0);

        // Restart, then reset at right slot k=8.
        adc_l      = 16'h3C5A;
        adc_r      = 16'hC3A5;
        next_drv_l = 16'h0F0F;
        next_drv_r = 16'hF0F0;
        en = 1'b1;
        @(negedge clk);
        chk("restart adc_req", 32'(adc_req), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (mslot == 1 && mk == 8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL timeout waiting for right slot k=8");
        end
        snap  = valid_cnt;
        rst_n = 1'b0;
        #1;
        chk("midframe reset outputs", 32'({bclk, lrck, adcdat, adc_req, dac_valid}), 32'd0);
        chk("midframe reset dac_l", 32'(dac_l), 32'd0);
        chk("midframe reset dac_r", 32'(dac_r), 32'd0);
        adc_l      = 16'h4321;
        adc_r      = 16'h8765;
        next_drv_l = 16'h1111;
        next_drv_r = 16'h2222;
        repeat (10) @(negedge clk);
        chk("in reset outputs", 32'({bclk, lrck, adcdat, adc_req, dac_valid}), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("no valid across reset", 32'(valid_cnt - snap), 32'd0);
        chk("post-reset adc_req", 32'(adc_req), 32'd1);
        chk("post-reset lrck left", 32'(lrck), 32'd0);
        wait_pulse(1, 400, ok);
        if (ok) begin
            chk("post-reset dac_l", 32'(dac_l), 32'h1111);
            chk("post-reset dac_r", 32'(dac_r), 32'h2222);
            chk("post-reset adcdat left", 32'(cap_l), 32'h4321);
            chk("post-reset adcdat right", 32'(cap_r), 32'h8765);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
